// File: rtl/bram_stream_reader_if.sv
// Output word stream of the BRAM read sequencer (valid/ready handshake).
interface bram_stream_reader_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Read-side BRAM sequencer: walks len addresses from base, hides the RAM read
// latency and presents the words as a backpressured valid/ready stream.
module bram_stream_reader #(
  parameter  int unsigned WIDTH = 0,
  parameter  int unsigned DEPTH = 1,
  localparam int unsigned DW    = 8 << WIDTH,
  localparam int unsigned AW    = 12 + DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  bram_stream_reader_if.master m
);

  localparam int unsigned FIFO_N = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              busy_d, done_d;
  logic [AW-1:0]     raddr_d;
  logic [AW:0]       rem_q, rem_d;
  logic              d1_q, d1_d, d2_q;
  logic [DW-1:0]     fifo_q [FIFO_N];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  occ_c;
  logic              pop_c, push_c, last_c;

  // Stream head decoded straight from FIFO registers
  assign m.m_valid = (count_q != CNT_W'(0));
  assign m.m_data  = fifo_q[rd_ptr_q];

  // Next-state, issue decision and FIFO occupancy
  always_comb begin
    state_d = state_q;
    busy_d  = busy;
    done_d  = 1'b0;
    raddr_d = raddr;
    rem_d   = rem_q;
    d1_d    = 1'b0;
    pop_c   = m.m_valid & m.m_ready;
    push_c  = d2_q;
    // Words already buffered or still in the RAM pipeline
    occ_c   = count_q + CNT_W'(d1_q) + CNT_W'(d2_q);
    last_c  = (rem_q == '0) && !d1_q && !d2_q && (count_q == CNT_W'(1)) && pop_c;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
            raddr_d = base;
            rem_d   = len - (AW+1)'(1);
            d1_d    = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if ((rem_q != '0) && ((occ_c - CNT_W'(pop_c)) <= CNT_W'(FIFO_N - 1))) begin
          raddr_d = raddr + AW'(1);
          rem_d   = rem_q - (AW+1)'(1);
          d1_d    = 1'b1;
        end
        if (last_c) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Control and read-latency pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      raddr   <= '0;
      rem_q   <= '0;
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      raddr   <= raddr_d;
      rem_q   <= rem_d;
      d1_q    <= d1_d;
      d2_q    <= d1_q;
    end
  end

  // Four-entry output FIFO; storage cleared so no stale word survives reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_N; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= rdata;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader with a registered-read RAM model.
module tb_bram_stream_reader;
  localparam int unsigned WIDTH = 0;
  localparam int unsigned DEPTH = 1;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 13;
  localparam int unsigned NADDR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;

  bram_stream_reader_if #(.DW(DW)) sif ();

  bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .base  (base),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .raddr (raddr),
    .rdata (rdata),
    .m     (sif)
  );

  always #5 clk = ~clk;

  // RAM contents RAM[a] = a[7:0], one-cycle registered read
  always @(posedge clk) rdata <= raddr[7:0];

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int addr_q[$];
  int issued = 0, accepted = 0, done_seen = 0, exp_done = 0;
  logic rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer yields addresses base..base+len-1 mod 2^AW
  task automatic push_expect(input int b, input int l);
    for (int i = 0; i < l; i++) begin
      int a;
      a = (b + i) % NADDR;
      exp_q.push_back(a & 255);
      addr_q.push_back(a);
    end
    exp_done++;
  endtask

  task automatic start_xfer(input int b, input int l);
    start = 1'b1;
    base  = AW'(b);
    len   = (AW+1)'(l);
    push_expect(b, l);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 32'(n < budget), 32'd1);
    @(posedge clk);
    #1;
    chk("done_count", done_seen, exp_done);
  endtask

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 sif.m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops expected words/addresses whenever the DUT presents them
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [AW-1:0] prev_raddr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0; prev_r = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("stall_valid", 32'(sif.m_valid), 32'd1);
        chk("stall_data", 32'(sif.m_data), 32'(prev_d));
      end
      if (sif.m_valid && sif.m_ready) begin
        accepted++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word actual=0x%0h required=none", sif.m_data);
        end else begin
          chk("m_data", 32'(sif.m_data), 32'(exp_q.pop_front()));
        end
      end
      if (busy && (!prev_busy || raddr != prev_raddr)) begin
        issued++;
        if (addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_issue actual=0x%0h required=none", raddr);
        end else begin
          chk("raddr", 32'(raddr), 32'(addr_q.pop_front()));
        end
      end
      if (busy) chk("outstanding_le4", 32'((issued - accepted) <= 4), 32'd1);
      if (done) begin
        done_seen++;
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_v = sif.m_valid; prev_r = sif.m_ready; prev_d = sif.m_data;
      prev_busy = busy; prev_done = done;
    end
    prev_raddr = raddr;
  end

  initial begin
    sif.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(sif.m_valid), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_data", 32'(sif.m_data), 32'd0);
    @(posedge clk);
    #1 sif.m_ready = 1'b1;

    // Basic transfer with exact latency and done/busy timing
    start_xfer(32'h010, 4);
    @(negedge clk); chk("lat_k0_valid", 32'(sif.m_valid), 32'd0);
    chk("lat_k0_busy", 32'(busy), 32'd1);
    @(negedge clk); chk("lat_k1_valid", 32'(sif.m_valid), 32'd0);
    @(negedge clk); chk("lat_k2_valid", 32'(sif.m_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(sif.m_valid), 32'd1);
      chk("stream_busy", 32'(busy), 32'd1);
      chk("stream_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_valid", 32'(sif.m_valid), 32'd0);
    @(negedge clk); chk("end_done_clear", 32'(done), 32'd0);
    @(posedge clk); #1;
    wait_idle(200);

    // Backpressure from the second word for 10 cycles
    start_xfer(32'h010, 4);
    repeat (3) @(posedge clk);
    #1 sif.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(sif.m_valid), 32'd1);
      chk("hold_data", 32'(sif.m_data), 32'h11);
    end
    @(posedge clk);
    #1 sif.m_ready = 1'b1;
    wait_idle(200);

    // Address wrap
    start_xfer(32'h1FFE, 4);
    wait_idle(200);

    // Zero-length command
    start_xfer(32'h055, 0);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_valid", 32'(sif.m_valid), 32'd0);
    @(negedge clk);
    chk("len0_done_clear", 32'(done), 32'd0);
    chk("len0_busy2", 32'(busy), 32'd0);
    @(posedge clk); #1;
    wait_idle(50);

    // Start while busy is ignored
    start_xfer(32'h010, 20);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; base = AW'(32'h100); len = (AW+1)'(7);
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle(500);

    // Random backpressure
    rnd_ready = 1'b1;
    start_xfer(int'($urandom_range(0, NADDR - 1)), 100);
    wait_idle(5000);
    for (int t = 0; t < 6; t++) begin
      start_xfer(int'($urandom_range(0, NADDR - 1)), int'($urandom_range(1, 40)));
      wait_idle(3000);
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 sif.m_ready = 1'b1;

    // Reset mid-transfer
    start_xfer(32'h200, 60);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete(); addr_q.delete();
    issued = 0; accepted = 0; exp_done--;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(sif.m_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_raddr", 32'(raddr), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(sif.m_valid), 32'd0);
    end
    @(posedge clk); #1;
    start_xfer(32'h0F0, 8);
    wait_idle(300);

    // Full address space
    start_xfer(0, NADDR);
    wait_idle(20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
